microsequencer: RTL and testbench

- Next-address unit that consumes the microstore control word and drives the microstore ROM address.
- Closes the loop encoder -> microstore_rom -> microsequencer -> microstore_rom.
- Each cycle it picks the next 7-bit state from one of four sources: the instruction encoder's dispatch address, the incremented current state, a jump target carried in the control word, or a return address.
- The choice is made by the control word's next-state field and a selected status condition.

---
 rtl/microsequencer_pkg.sv | 25 ++
 rtl/microseq_stack.sv | 43 ++++
 rtl/microsequencer.sv | 127 ++++++++++++
 tb/tb_microsequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/microsequencer_pkg.sv
// Shared microsequencer encodings and the microstore address width.
// The address width is shared with the instruction encoder and the microstore ROM.
package microsequencer_pkg;

    localparam int unsigned MSEQ_AW = 7;

    typedef enum logic [2:0] {
        NS_ENCODER = 3'd0,
        NS_INCR    = 3'd1,
        NS_JUMP    = 3'd2,
        NS_CJUMP   = 3'd3,
        NS_WAIT    = 3'd4,
        NS_CALL    = 3'd5,
        NS_RETURN  = 3'd6,
        NS_HOLD    = 3'd7
    } ns_sel_e;

    typedef enum logic [1:0] {
        CS_MFC  = 2'd0,
        CS_PASS = 2'd1,
        CS_Z    = 2'd2,
        CS_TRUE = 2'd3
    } cond_sel_e;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for the microsequencer.
// When it is full, a push overwrites the oldest entry because the pointer wraps.
module microseq_stack #(
    parameter int unsigned AW    = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_c,
    output logic          full_c,
    output logic          empty_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   count;

    assign full_c  = (count == (PW+1)'(DEPTH));
    assign empty_c = (count == '0);
    assign top_c   = mem[ptr - PW'(1)];

    // The count saturates at DEPTH, so after a wrap it still counts the valid entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full_c) count <= count + (PW+1)'(1);
        end else if (pop && !empty_c) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Next-address unit for the microstore ROM.
// Defining MSEQ_STACK_EN adds a CALL/RETURN return stack; without it CALL acts as JUMP.
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int unsigned    AW          = MSEQ_AW,
    parameter logic [AW-1:0]  RESET_STATE = '0,
    parameter int unsigned    STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] enc_addr,
    input  logic [2:0]    ns_sel,
    input  logic [AW-1:0] cr_addr,
    input  logic [1:0]    cond_sel,
    input  logic          cond_inv,
    input  logic          mfc,
    input  logic          cond_pass,
    input  logic          z_flag,
    input  logic          stall,
    output logic [AW-1:0] state,
    output logic          dispatch,
    output logic          seq_err
);

    if ((STACK_DEPTH == 0) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("STACK_DEPTH must be a power of two");
    end

    logic [AW-1:0] inc_c;
    logic          cond_c;
    logic [AW-1:0] state_nxt;
    logic          dispatch_nxt;
    logic          err_nxt;

    assign inc_c = state + AW'(1);

`ifdef MSEQ_STACK_EN
    logic          push_c;
    logic          pop_c;
    logic [AW-1:0] top_c;
    logic          full_c;
    logic          empty_c;

    microseq_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (inc_c),
        .top_c     (top_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );
`endif

    // Select the status condition, optionally inverted.
    always_comb begin
        cond_c = 1'b0;
        case (cond_sel)
            CS_MFC:  cond_c = mfc;
            CS_PASS: cond_c = cond_pass;
            CS_Z:    cond_c = z_flag;
            default: cond_c = 1'b1;
        endcase
        cond_c = cond_c ^ cond_inv;
    end

    // Select the next address. A stall leaves every default in place.
    always_comb begin
        state_nxt    = state;
        dispatch_nxt = 1'b0;
        err_nxt      = seq_err;
`ifdef MSEQ_STACK_EN
        push_c       = 1'b0;
        pop_c        = 1'b0;
`endif
        if (!stall) begin
            case (ns_sel)
                NS_ENCODER: begin
                    state_nxt    = enc_addr;
                    dispatch_nxt = 1'b1;
                end
                NS_INCR:  state_nxt = inc_c;
                NS_JUMP:  state_nxt = cr_addr;
                NS_CJUMP: state_nxt = cond_c ? cr_addr : inc_c;
                NS_WAIT:  state_nxt = cond_c ? inc_c : state;
`ifdef MSEQ_STACK_EN
                NS_CALL: begin
                    state_nxt = cr_addr;
                    push_c    = 1'b1;
                    if (full_c) err_nxt = 1'b1;
                end
                NS_RETURN: begin
                    if (empty_c) begin
                        state_nxt = RESET_STATE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = top_c;
                        pop_c     = 1'b1;
                    end
                end
`else
                NS_CALL:   state_nxt = cr_addr;
                NS_RETURN: state_nxt = RESET_STATE;
`endif
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RESET_STATE;
            dispatch <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dispatch <= dispatch_nxt;
            seq_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Directed, table-driven bench for microsequencer.
// The same bench works with and without MSEQ_STACK_EN defined.
module tb_microsequencer;

`ifdef MSEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       stl;
        logic [2:0] ns;
        logic [6:0] cr;
        logic [6:0] enc;
        logic [1:0] cs;
        logic       inv;
        logic       mfc;
        logic       pass;
        logic       z;
        logic [6:0] exp_state;
        logic       exp_disp;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, stall, cond_inv, mfc, cond_pass, z_flag;
    logic [2:0] ns_sel;
    logic [1:0] cond_sel;
    logic [6:0] enc_addr, cr_addr;
    logic [6:0] state;
    logic       dispatch, seq_err;

    int   nvec = 0;
    int   nerr = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    microsequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enc_addr  (enc_addr),
        .ns_sel    (ns_sel),
        .cr_addr   (cr_addr),
        .cond_sel  (cond_sel),
        .cond_inv  (cond_inv),
        .mfc       (mfc),
        .cond_pass (cond_pass),
        .z_flag    (z_flag),
        .stall     (stall),
        .state     (state),
        .dispatch  (dispatch),
        .seq_err   (seq_err)
    );

    task automatic add(input logic rst, input logic stl, input logic [2:0] ns,
                       input logic [6:0] cr, input logic [6:0] enc, input logic [1:0] cs,
                       input logic inv, input logic m, input logic p, input logic z,
                       input logic [6:0] es, input logic ed, input logic ee);
        vec_t v;
        v.rst = rst; v.stl = stl; v.ns = ns; v.cr = cr; v.enc = enc; v.cs = cs;
        v.inv = inv; v.mfc = m; v.pass = p; v.z = z;
        v.exp_state = es; v.exp_disp = ed; v.exp_err = ee;
        vq.push_back(v);
    endtask

    // Drive one vector, take one rising edge, then check the registered outputs.
    task automatic apply(input vec_t v, input int idx);
        reset = v.rst; stall = v.stl; ns_sel = v.ns; cr_addr = v.cr; enc_addr = v.enc;
        cond_sel = v.cs; cond_inv = v.inv; mfc = v.mfc; cond_pass = v.pass; z_flag = v.z;
        @(posedge clk);
        #1;
        nvec++;
        if (state !== v.exp_state || dispatch !== v.exp_disp || seq_err !== v.exp_err) begin
            nerr++;
            $display("FAIL vec%0d: state=%0d dispatch=%b seq_err=%b, expected state=%0d dispatch=%b seq_err=%b",
                     idx, state, dispatch, seq_err, v.exp_state, v.exp_disp, v.exp_err);
        end
    endtask

    initial begin
        vec_t v;
        // Columns: rst stl ns cr enc cs inv mfc pass z | exp_state disp err
        add(1, 1, 3'd2, 7'd50, 7'd0, 2'd0, 0, 0, 0, 0,   7'd0,   0, 0); // reset beats stall and JUMP
        add(0, 0, 3'd2, 7'd126, 7'd0, 2'd0, 0, 0, 0, 0,  7'd126, 0, 0);
        add(0, 0, 3'd1, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    7'd127, 0, 0);
        add(0, 0, 3'd1, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    7'd0,   0, 0); // increment wraps
        add(0, 0, 3'd0, 7'd0, 7'd23, 2'd0, 0, 0, 0, 0,   7'd23,  1, 0); // dispatch
        add(0, 0, 3'd1, 7'd0, 7'd99, 2'd0, 0, 0, 0, 0,   7'd24,  0, 0);
        add(0, 0, 3'd2, 7'd10, 7'd0, 2'd0, 0, 0, 0, 0,   7'd10,  0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 3'd4, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0, 7'd10, 0, 0); // WAIT for mfc
        add(0, 0, 3'd4, 7'd0, 7'd0, 2'd0, 0, 1, 0, 0,    7'd11,  0, 0);
        add(0, 0, 3'd2, 7'd10, 7'd0, 2'd0, 0, 0, 0, 0,   7'd10,  0, 0);
        add(0, 0, 3'd4, 7'd0, 7'd0, 2'd0, 1, 1, 0, 0,    7'd10,  0, 0); // inverted WAIT
        add(0, 0, 3'd4, 7'd0, 7'd0, 2'd0, 1, 0, 0, 0,    7'd11,  0, 0);
        add(0, 0, 3'd2, 7'd5, 7'd0, 2'd0, 0, 0, 0, 0,    7'd5,   0, 0);
        add(0, 0, 3'd3, 7'd40, 7'd0, 2'd1, 0, 0, 0, 0,   7'd6,   0, 0); // CJUMP not taken
        add(0, 0, 3'd0, 7'd0, 7'd30, 2'd0, 0, 0, 0, 0,   7'd30,  1, 0);
        add(0, 1, 3'd0, 7'd0, 7'd99, 2'd0, 0, 0, 0, 0,   7'd30,  0, 0); // stall clears dispatch
        add(0, 1, 3'd3, 7'd40, 7'd0, 2'd1, 0, 0, 1, 0,   7'd30,  0, 0);
        add(0, 0, 3'd3, 7'd40, 7'd0, 2'd1, 0, 0, 1, 0,   7'd40,  0, 0); // CJUMP taken
        add(0, 0, 3'd3, 7'd70, 7'd0, 2'd2, 1, 0, 0, 1,   7'd41,  0, 0); // z inverted -> not taken
        add(0, 0, 3'd3, 7'd70, 7'd0, 2'd3, 0, 0, 0, 0,   7'd70,  0, 0); // constant-true
        add(0, 0, 3'd7, 7'd5, 7'd0, 2'd3, 0, 1, 1, 1,    7'd70,  0, 0); // HOLD
        add(0, 0, 3'd7, 7'd5, 7'd0, 2'd3, 0, 1, 1, 1,    7'd70,  0, 0);
        add(1, 0, 3'd1, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    7'd0,   0, 0); // reset exits HOLD
        // Call/return
        add(0, 0, 3'd2, 7'd8, 7'd0, 2'd0, 0, 0, 0, 0,    7'd8,   0, 0);
        add(0, 0, 3'd5, 7'd60, 7'd0, 2'd0, 0, 0, 0, 0,   7'd60,  0, 0);
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    STK ? 7'd9 : 7'd0, 0, 0);
        add(0, 0, 3'd5, 7'd20, 7'd0, 2'd0, 0, 0, 0, 0,   7'd20,  0, 0);
        add(0, 0, 3'd5, 7'd30, 7'd0, 2'd0, 0, 0, 0, 0,   7'd30,  0, 0);
        add(0, 0, 3'd5, 7'd40, 7'd0, 2'd0, 0, 0, 0, 0,   7'd40,  0, 0);
        add(0, 0, 3'd5, 7'd50, 7'd0, 2'd0, 0, 0, 0, 0,   7'd50,  0, 0);
        add(0, 0, 3'd5, 7'd60, 7'd0, 2'd0, 0, 0, 0, 0,   7'd60,  0, STK); // fifth call overflows
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    STK ? 7'd51 : 7'd0, 0, STK);
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    STK ? 7'd41 : 7'd0, 0, STK);
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    STK ? 7'd31 : 7'd0, 0, STK);
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    STK ? 7'd21 : 7'd0, 0, STK);
        add(0, 0, 3'd2, 7'd15, 7'd0, 2'd0, 0, 0, 0, 0,   7'd15,  0, STK);
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    7'd0,   0, STK); // return on empty stack
        add(1, 0, 3'd0, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    7'd0,   0, 0);   // reset clears error
        add(0, 0, 3'd6, 7'd0, 7'd0, 2'd0, 0, 0, 0, 0,    7'd0,   0, STK); // empty right after reset

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // A stall held over several cycles freezes the state and keeps dispatch low.
        v = '{rst: 0, stl: 0, ns: 3'd2, cr: 7'd77, enc: 7'd0, cs: 2'd0, inv: 0, mfc: 0,
              pass: 0, z: 0, exp_state: 7'd77, exp_disp: 0, exp_err: STK};
        apply(v, 100);
        for (int i = 0; i < 4; i++) begin
            v.stl = 1; v.ns = 3'd0; v.enc = 7'd3; v.exp_state = 7'd77;
            apply(v, 101 + i);
        end
        v.stl = 0; v.ns = 3'd1; v.exp_state = 7'd78;
        apply(v, 105);
        v.ns = 3'd0; v.enc = 7'd3; v.exp_state = 7'd3; v.exp_disp = 1;
        apply(v, 106);
        v.ns = 3'd7; v.exp_state = 7'd3; v.exp_disp = 0;
        apply(v, 107);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
